// File: rtl/dmem_responder_if.sv
// Data-RAM bus between dmem_responder (master) and the data RAM (slave).
interface dmem_responder_if;
  logic [15:0] ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_re;
  logic        ram_we;
  logic [15:0] ram_rdata;
  logic        ram_ack;

  modport master (
    output ram_addr, ram_wdata, ram_re, ram_we,
    input  ram_rdata, ram_ack
  );

  modport slave (
    input  ram_addr, ram_wdata, ram_re, ram_we,
    output ram_rdata, ram_ack
  );
endinterface

// File: rtl/dmem_responder.sv
// Memory-stage responder: runs the data-RAM strobe/ack handshake and hands one result per instruction to MEM/WB.
// Optional one-entry store-to-load forwarding buffer enabled by defining DMEM_FWD_EN.
module dmem_responder #(
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      DataAddress,
  input  logic             ReadMem,
  input  logic             WriteMem,
  input  logic [15:0]      DataIn,
  input  logic [1:0]       quarter,
  input  logic             write,
  input  logic [3:0]       writeReg,
  output logic             stall,
  dmem_responder_if.master ram,
  output logic             o_valid,
  output logic [15:0]      o_Result,
  output logic             o_err,
  output logic             o_write,
  output logic [3:0]       o_writeReg,
  output logic [1:0]       o_quarter,
  output logic [1:0]       dbg_state
);

  // RAM handshake: ram_re/ram_we pulse for exactly one cycle (REQ) while ram_addr/ram_wdata
  // stay stable until RESP ends; the RAM completes with a one-cycle ram_ack carrying ram_rdata.
  // An ack is only honoured in REQ or WAIT; after ACK_TIMEOUT WAIT cycles the access is dropped.
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_e;

  localparam logic [7:0] TIMEOUT_CNT = ACK_TIMEOUT[7:0];

  state_e      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        is_wr_q, is_wr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        re_q, re_d;
  logic        we_q, we_d;
  logic        valid_q, valid_d;
  logic [15:0] res_q, res_d;
  logic        err_q, err_d;
  logic        owrite_q, owrite_d;
  logic [3:0]  owreg_q, owreg_d;
  logic [1:0]  oquart_q, oquart_d;
  logic        cw_q, cw_d;
  logic [3:0]  cwreg_q, cwreg_d;
  logic [1:0]  cq_q, cq_d;
  logic        finish, timed_out;
  logic        fwd_hit;
  logic [15:0] fwd_data;
  logic        need_ram;

`ifdef DMEM_FWD_EN
  logic        sb_valid_q, sb_valid_d;
  logic [15:0] sb_addr_q, sb_addr_d;
  logic [15:0] sb_data_q, sb_data_d;

  assign fwd_hit  = ReadMem & ~WriteMem & sb_valid_q & (sb_addr_q == DataAddress);
  assign fwd_data = sb_data_q;
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = 16'h0000;
`endif

  // A write always needs the RAM; a read only when it misses the store buffer.
  assign need_ram = WriteMem | (ReadMem & ~fwd_hit);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    is_wr_d   = is_wr_q;
    cnt_d     = cnt_q;
    re_d      = 1'b0;
    we_d      = 1'b0;
    valid_d   = 1'b0;
    res_d     = res_q;
    err_d     = err_q;
    owrite_d  = owrite_q;
    owreg_d   = owreg_q;
    oquart_d  = oquart_q;
    cw_d      = cw_q;
    cwreg_d   = cwreg_q;
    cq_d      = cq_q;
    finish    = 1'b0;
    timed_out = 1'b0;
`ifdef DMEM_FWD_EN
    sb_valid_d = sb_valid_q;
    sb_addr_d  = sb_addr_q;
    sb_data_d  = sb_data_q;
`endif

    case (state_q)
      IDLE: begin
        if (need_ram) begin
          addr_d  = DataAddress;
          wdata_d = DataIn;
          is_wr_d = WriteMem;
          cw_d    = write;
          cwreg_d = writeReg;
          cq_d    = quarter;
          re_d    = ReadMem & ~WriteMem;
          we_d    = WriteMem;
          state_d = REQ;
        end else begin
          valid_d  = 1'b1;
          res_d    = fwd_hit ? fwd_data : DataAddress;
          err_d    = 1'b0;
          owrite_d = write;
          owreg_d  = writeReg;
          oquart_d = quarter;
        end
      end
      REQ: begin
        if (ram.ram_ack) begin
          finish = 1'b1;
        end else begin
          state_d = WAIT;
          cnt_d   = 8'd1;
        end
      end
      WAIT: begin
        if (ram.ram_ack) begin
          finish = 1'b1;
        end else if (cnt_q == TIMEOUT_CNT) begin
          finish    = 1'b1;
          timed_out = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
      default: state_d = IDLE;
    endcase

    if (finish) begin
      state_d  = RESP;
      valid_d  = 1'b1;
      err_d    = timed_out;
      res_d    = (timed_out || is_wr_q) ? 16'h0000 : ram.ram_rdata;
      owrite_d = cw_q & ~timed_out;
      owreg_d  = cwreg_q;
      oquart_d = cq_q;
    end

`ifdef DMEM_FWD_EN
    if (finish && is_wr_q) begin
      if (timed_out) begin
        sb_valid_d = 1'b0;
      end else begin
        sb_valid_d = 1'b1;
        sb_addr_d  = addr_q;
        sb_data_d  = wdata_q;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= 16'h0000;
      wdata_q  <= 16'h0000;
      is_wr_q  <= 1'b0;
      cnt_q    <= 8'd0;
      re_q     <= 1'b0;
      we_q     <= 1'b0;
      valid_q  <= 1'b0;
      res_q    <= 16'h0000;
      err_q    <= 1'b0;
      owrite_q <= 1'b0;
      owreg_q  <= 4'd0;
      oquart_q <= 2'd0;
      cw_q     <= 1'b0;
      cwreg_q  <= 4'd0;
      cq_q     <= 2'd0;
`ifdef DMEM_FWD_EN
      sb_valid_q <= 1'b0;
      sb_addr_q  <= 16'h0000;
      sb_data_q  <= 16'h0000;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      is_wr_q  <= is_wr_d;
      cnt_q    <= cnt_d;
      re_q     <= re_d;
      we_q     <= we_d;
      valid_q  <= valid_d;
      res_q    <= res_d;
      err_q    <= err_d;
      owrite_q <= owrite_d;
      owreg_q  <= owreg_d;
      oquart_q <= oquart_d;
      cw_q     <= cw_d;
      cwreg_q  <= cwreg_d;
      cq_q     <= cq_d;
`ifdef DMEM_FWD_EN
      sb_valid_q <= sb_valid_d;
      sb_addr_q  <= sb_addr_d;
      sb_data_q  <= sb_data_d;
`endif
    end
  end

  assign stall         = (state_q == REQ) || (state_q == WAIT) || ((state_q == IDLE) && need_ram);
  assign ram.ram_addr  = addr_q;
  assign ram.ram_wdata = wdata_q;
  assign ram.ram_re    = re_q;
  assign ram.ram_we    = we_q;
  assign o_valid       = valid_q;
  assign o_Result      = res_q;
  assign o_err         = err_q;
  assign o_write       = owrite_q;
  assign o_writeReg    = owreg_q;
  assign o_quarter     = oquart_q;
  assign dbg_state     = state_q;

endmodule
